// File: rtl/clint_timer_irq_pkg.sv
// Shared definitions for the core-local interruptor: register offsets,
// protocol FSM state encoding and the byte-strobe merge helper.
// Optional feature macro used by the design: CLINT_PRESCALER_EN.
package clint_timer_irq_pkg;

  // Register offsets relative to the CLINT base address.
  localparam logic [31:0] CLINT_MSIP_OFS        = 32'h0000_0000;
  localparam logic [31:0] CLINT_MTIMECMP_LO_OFS = 32'h0000_4000;
  localparam logic [31:0] CLINT_MTIMECMP_HI_OFS = 32'h0000_4004;
  localparam logic [31:0] CLINT_MTIME_LO_OFS    = 32'h0000_BFF8;
  localparam logic [31:0] CLINT_MTIME_HI_OFS    = 32'h0000_BFFC;

  // mtimecmp comes out of reset at all-ones so the timer cannot fire
  // before software programs it.
  localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {
    CLINT_FSM_IDLE = 1'b0,
    CLINT_FSM_RESP = 1'b1
  } clint_fsm_e;

  // Replace only the bytes whose strobe is set.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_val[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_mtime_counter.sv
// 64-bit mtime counter with half-word bus load (byte strobes) and an
// optional tick prescaler enabled by the CLINT_PRESCALER_EN macro.
// Ports: clk/reset (sync, active-low), wr_lo_i/wr_hi_i half-word load
// strobes, wdata_i/wstrb_i load data and byte enables, mtime_o count value.
module clint_mtime_counter
  import clint_timer_irq_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic [63:0] mtime_o
);

  logic [63:0] mtime_q;
  logic [63:0] mtime_d;
  logic        wr_any;
  logic        tick;

  assign wr_any = wr_lo_i | wr_hi_i;

`ifdef CLINT_PRESCALER_EN
  localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

  logic [15:0] presc_q;
  logic [15:0] presc_d;

  assign tick = (presc_q == DIV_LAST);

  // A load restarts the prescaler so the first increment after a write
  // lands a full TICK_DIV cycles later.
  always_comb begin
    presc_d = presc_q + 16'd1;
    if (tick || wr_any) begin
      presc_d = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q <= 16'd0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // A bus load suppresses the increment entirely, so the written half holds
  // exactly the written value and the other half is left untouched.
  always_comb begin
    mtime_d = mtime_q;
    if (wr_lo_i) begin
      mtime_d[31:0] = apply_wstrb(mtime_q[31:0], wdata_i, wstrb_i);
    end
    if (wr_hi_i) begin
      mtime_d[63:32] = apply_wstrb(mtime_q[63:32], wdata_i, wstrb_i);
    end
    if (!wr_any && tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mtime_q <= 64'd0;
    end else begin
      mtime_q <= mtime_d;
    end
  end

  assign mtime_o = mtime_q;

endmodule

// File: rtl/clint_timer_irq.sv
// Core-local interruptor: memory-mapped mtime/mtimecmp/msip on a 32-bit
// request/response bus, driving the machine timer and software interrupts.
// Ports: req_* request channel (ready high in IDLE), resp_* response channel
// (valid one cycle after accept, held until resp_ready_in), timer_int_out
// and software_int_out to the CSR block. Optional macro: CLINT_PRESCALER_EN.
module clint_timer_irq
  import clint_timer_irq_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid_in,
  output logic            req_ready_out,
  input  logic            req_we_in,
  input  logic [31:0]     req_addr_in,
  input  logic [XLEN-1:0] req_wdata_in,
  input  logic [3:0]      req_wstrb_in,
  output logic            resp_valid_out,
  input  logic            resp_ready_in,
  output logic [XLEN-1:0] resp_rdata_out,
  output logic            resp_err_out,
  output logic            timer_int_out,
  output logic            software_int_out
);

  clint_fsm_e      state_q;
  logic            req_ready_q;
  logic            resp_valid_q;
  logic            resp_err_q;
  logic [XLEN-1:0] resp_rdata_q;

  logic [63:0] mtimecmp_q;
  logic [63:0] mtimecmp_d;
  logic        msip_q;
  logic        msip_d;
  logic        timer_int_q;
  logic [63:0] mtime;

  logic [31:0] ofs;
  logic        aligned;
  logic        hit_msip;
  logic        hit_cmp_lo;
  logic        hit_cmp_hi;
  logic        hit_mt_lo;
  logic        hit_mt_hi;
  logic        mapped;
  logic        accept;
  logic        wr_ok;
  logic        wr_bytes;
  logic [31:0] rd_data;

  // ---------------------------------------------------------------- decode
  assign ofs        = req_addr_in - BASE_ADDR;
  assign aligned    = (req_addr_in[1:0] == 2'b00);
  assign hit_msip   = aligned && (ofs == CLINT_MSIP_OFS);
  assign hit_cmp_lo = aligned && (ofs == CLINT_MTIMECMP_LO_OFS);
  assign hit_cmp_hi = aligned && (ofs == CLINT_MTIMECMP_HI_OFS);
  assign hit_mt_lo  = aligned && (ofs == CLINT_MTIME_LO_OFS);
  assign hit_mt_hi  = aligned && (ofs == CLINT_MTIME_HI_OFS);
  assign mapped     = hit_msip | hit_cmp_lo | hit_cmp_hi | hit_mt_lo | hit_mt_hi;

  assign accept   = (state_q == CLINT_FSM_IDLE) && req_valid_in;
  assign wr_ok    = accept && req_we_in && mapped;
  // An all-zero strobe is a pure no-op, including leaving mtime ticking.
  assign wr_bytes = |req_wstrb_in;

  // Read data reflects register contents before this cycle's write/tick.
  always_comb begin
    rd_data = 32'd0;
    if (hit_msip) begin
      rd_data = {31'd0, msip_q};
    end else if (hit_cmp_lo) begin
      rd_data = mtimecmp_q[31:0];
    end else if (hit_cmp_hi) begin
      rd_data = mtimecmp_q[63:32];
    end else if (hit_mt_lo) begin
      rd_data = mtime[31:0];
    end else if (hit_mt_hi) begin
      rd_data = mtime[63:32];
    end
  end

  // ------------------------------------------------------------ registers
  always_comb begin
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wr_ok && hit_cmp_lo) begin
      mtimecmp_d[31:0] = apply_wstrb(mtimecmp_q[31:0], req_wdata_in, req_wstrb_in);
    end
    if (wr_ok && hit_cmp_hi) begin
      mtimecmp_d[63:32] = apply_wstrb(mtimecmp_q[63:32], req_wdata_in, req_wstrb_in);
    end
    if (wr_ok && hit_msip && req_wstrb_in[0]) begin
      msip_d = req_wdata_in[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mtimecmp_q  <= CLINT_MTIMECMP_RST;
      msip_q      <= 1'b0;
      timer_int_q <= 1'b0;
    end else begin
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      // Compare of the current values, so the interrupt follows the
      // condition by exactly one cycle in both directions.
      timer_int_q <= (mtime >= mtimecmp_q);
    end
  end

  clint_mtime_counter #(
    .TICK_DIV (TICK_DIV)
  ) u_mtime (
    .clk     (clk),
    .reset   (reset),
    .wr_lo_i (wr_ok && hit_mt_lo && wr_bytes),
    .wr_hi_i (wr_ok && hit_mt_hi && wr_bytes),
    .wdata_i (req_wdata_in),
    .wstrb_i (req_wstrb_in),
    .mtime_o (mtime)
  );

  // ------------------------------------------------------------- protocol
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= CLINT_FSM_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        CLINT_FSM_IDLE: begin
          if (req_valid_in) begin
            state_q      <= CLINT_FSM_RESP;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= !mapped;
            resp_rdata_q <= (req_we_in || !mapped) ? '0 : rd_data;
          end
        end
        CLINT_FSM_RESP: begin
          if (resp_ready_in) begin
            state_q      <= CLINT_FSM_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= CLINT_FSM_IDLE;
        end
      endcase
    end
  end

  assign req_ready_out    = req_ready_q;
  assign resp_valid_out   = resp_valid_q;
  assign resp_rdata_out   = resp_rdata_q;
  assign resp_err_out     = resp_err_q;
  assign timer_int_out    = timer_int_q;
  assign software_int_out = msip_q;

endmodule

// File: tb/tb_clint_timer_irq.sv
module tb_clint_timer_irq;

  localparam logic [31:0] BASE = 32'h0200_0000;
`ifdef CLINT_PRESCALER_EN
  localparam int unsigned TB_TICK_DIV = 4;
`else
  localparam int unsigned TB_TICK_DIV = 1;
`endif

  logic        clk;
  logic        reset;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_we_in;
  logic [31:0] req_addr_in;
  logic [31:0] req_wdata_in;
  logic [3:0]  req_wstrb_in;
  logic        resp_valid_out;
  logic        resp_ready_in;
  logic [31:0] resp_rdata_out;
  logic        resp_err_out;
  logic        timer_int_out;
  logic        software_int_out;

  clint_timer_irq #(
    .XLEN      (32),
    .BASE_ADDR (BASE),
    .TICK_DIV  (TB_TICK_DIV)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid_in     (req_valid_in),
    .req_ready_out    (req_ready_out),
    .req_we_in        (req_we_in),
    .req_addr_in      (req_addr_in),
    .req_wdata_in     (req_wdata_in),
    .req_wstrb_in     (req_wstrb_in),
    .resp_valid_out   (resp_valid_out),
    .resp_ready_in    (resp_ready_in),
    .resp_rdata_out   (resp_rdata_out),
    .resp_err_out     (resp_err_out),
    .timer_int_out    (timer_int_out),
    .software_int_out (software_int_out)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  // Transaction-level model of the register file and the interrupt lines.
  logic [63:0] m_mtime, m_cmp;
  logic        m_msip, m_tint, m_busy, m_err, m_live;
  logic [31:0] m_rdata;
  int unsigned m_presc;

  initial m_live = 1'b0;

  always @(posedge clk) begin : model
    logic [31:0] ofs;
    logic [63:0] nxt;
    logic        hit, loaded, nt;
    if (!reset) begin
      m_mtime = 64'd0; m_cmp = '1; m_msip = 1'b0; m_tint = 1'b0;
      m_busy = 1'b0; m_err = 1'b0; m_rdata = 32'd0; m_presc = 0; m_live = 1'b1;
    end else if (m_live) begin
      nt = (m_mtime >= m_cmp);
      nxt = m_mtime;
      loaded = 1'b0;
      if (!m_busy) begin
        if (req_valid_in) begin
          ofs = req_addr_in - BASE;
          hit = (req_addr_in[1:0] == 2'b00) &&
                (ofs == 32'h0 || ofs == 32'h4000 || ofs == 32'h4004 || ofs == 32'hBFF8 || ofs == 32'hBFFC);
          m_err = !hit;
          m_rdata = 32'd0;
          m_busy = 1'b1;
          if (hit && !req_we_in) begin
            case (ofs)
              32'h0000: m_rdata = {31'd0, m_msip};
              32'h4000: m_rdata = m_cmp[31:0];
              32'h4004: m_rdata = m_cmp[63:32];
              32'hBFF8: m_rdata = m_mtime[31:0];
              default:  m_rdata = m_mtime[63:32];
            endcase
          end
          if (hit && req_we_in) begin
            case (ofs)
              32'h0000: if (req_wstrb_in[0]) m_msip = req_wdata_in[0];
              32'h4000: m_cmp[31:0] = merge(m_cmp[31:0], req_wdata_in, req_wstrb_in);
              32'h4004: m_cmp[63:32] = merge(m_cmp[63:32], req_wdata_in, req_wstrb_in);
              32'hBFF8: if (|req_wstrb_in) begin nxt[31:0] = merge(m_mtime[31:0], req_wdata_in, req_wstrb_in); loaded = 1'b1; end
              default:  if (|req_wstrb_in) begin nxt[63:32] = merge(m_mtime[63:32], req_wdata_in, req_wstrb_in); loaded = 1'b1; end
            endcase
          end
        end
      end else if (resp_ready_in) begin
        m_busy = 1'b0;
      end
      if (loaded) begin
        m_mtime = nxt;
        m_presc = 0;
      end else if (m_presc == TB_TICK_DIV - 1) begin
        m_presc = 0;
        m_mtime = m_mtime + 64'd1;
      end else begin
        m_presc = m_presc + 1;
      end
      m_tint = nt;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      check("req_ready", req_ready_out, !m_busy);
      check("resp_valid", resp_valid_out, m_busy);
      if (m_busy) begin
        check("resp_rdata", resp_rdata_out, m_rdata);
        check("resp_err", resp_err_out, m_err);
      end
      check("timer_int", timer_int_out, m_tint);
      check("software_int", software_int_out, m_msip);
    end
  end

  logic [31:0] rd;
  logic        er;

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // One complete transaction: accept on the first edge, response visible
  // right after it, consumed on the second edge (resp_ready_in high).
  task automatic bus(input logic we, input logic [31:0] ofs, input logic [31:0] wd,
                     input logic [3:0] st, output logic [31:0] rdo, output logic ero);
    req_valid_in = 1'b1; req_we_in = we; req_addr_in = BASE + ofs;
    req_wdata_in = wd; req_wstrb_in = st;
    @(posedge clk); #1;
    req_valid_in = 1'b0;
    check("resp_valid_1cyc", resp_valid_out, 1'b1);
    rdo = resp_rdata_out;
    ero = resp_err_out;
    @(posedge clk); #1;
  endtask

  initial begin
    clk = 1'b0; reset = 1'b0; req_valid_in = 1'b0; req_we_in = 1'b0;
    req_addr_in = 32'd0; req_wdata_in = 32'd0; req_wstrb_in = 4'd0; resp_ready_in = 1'b1;

    // Reset state and first reads.
    do_reset();
    check("rst_req_ready", req_ready_out, 1'b1);
    check("rst_resp_valid", resp_valid_out, 1'b0);
    check("rst_rdata", resp_rdata_out, 32'd0);
    check("rst_timer", timer_int_out, 1'b0);
    check("rst_sw", software_int_out, 1'b0);
`ifdef CLINT_PRESCALER_EN
    repeat (8) @(posedge clk); #1;
    bus(1'b0, 32'hBFF8, 32'd0, 4'h0, rd, er);
    check("presc_mtime_after_8", rd, 32'd2);
`endif
    bus(1'b0, 32'h4004, 32'd0, 4'h0, rd, er);
    check("rst_cmp_hi", rd, 32'hFFFF_FFFF);
    check("rst_cmp_hi_err", er, 1'b0);
    repeat (1000) @(posedge clk); #1;
    check("timer_quiet_1000", timer_int_out, 1'b0);

    // Timer compare: mtime counts 1,2,3.. after the reset release edge.
    do_reset();
    bus(1'b1, 32'h4000, 32'd20, 4'hF, rd, er);
    bus(1'b1, 32'h4004, 32'd0, 4'hF, rd, er);
`ifndef CLINT_PRESCALER_EN
    repeat (16) @(posedge clk); #1;
    check("timer_at_mtime20", timer_int_out, 1'b0);
    @(posedge clk); #1;
    check("timer_rise", timer_int_out, 1'b1);
`else
    repeat (90) @(posedge clk); #1;
    check("timer_presc_high", timer_int_out, 1'b1);
`endif
    bus(1'b1, 32'h4004, 32'd1, 4'hF, rd, er);
    check("timer_fall", timer_int_out, 1'b0);

    // Byte strobes and zero-strobe write.
    bus(1'b1, 32'h4000, 32'hAABB_CCDD, 4'b0010, rd, er);
    bus(1'b0, 32'h4000, 32'd0, 4'h0, rd, er);
    check("strobe_merge", rd, 32'h0000_CC14);
    bus(1'b1, 32'h4000, 32'd0, 4'h0, rd, er);
    check("zero_strobe_err", er, 1'b0);
    bus(1'b0, 32'h4000, 32'd0, 4'h0, rd, er);
    check("zero_strobe_nochange", rd, 32'h0000_CC14);

    // Response held under backpressure.
    resp_ready_in = 1'b0;
    req_valid_in = 1'b1; req_we_in = 1'b0; req_addr_in = BASE + 32'h4000; req_wstrb_in = 4'h0;
    @(posedge clk); #1;
    req_valid_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", resp_valid_out, 1'b1);
      check("hold_rdata", resp_rdata_out, 32'h0000_CC14);
      check("hold_ready", req_ready_out, 1'b0);
      @(posedge clk); #1;
    end
    resp_ready_in = 1'b1;
    @(posedge clk); #1;
    check("hold_release", req_ready_out, 1'b1);

    // Unmapped and misaligned accesses.
    bus(1'b0, 32'h0008, 32'd0, 4'h0, rd, er);
    check("unmapped_err", er, 1'b1);
    check("unmapped_rdata", rd, 32'd0);
    bus(1'b0, 32'h4002, 32'd0, 4'h0, rd, er);
    check("misalign_err", er, 1'b1);
    check("misalign_rdata", rd, 32'd0);
    bus(1'b1, 32'h4002, 32'hDEAD_0000, 4'hF, rd, er);
    check("misalign_wr_err", er, 1'b1);
    bus(1'b0, 32'h4000, 32'd0, 4'h0, rd, er);
    check("misalign_nochange", rd, 32'h0000_CC14);

    // Software interrupt.
    bus(1'b1, 32'h0000, 32'hFFFF_FFFF, 4'hF, rd, er);
    check("msip_set", software_int_out, 1'b1);
    bus(1'b0, 32'h0000, 32'd0, 4'h0, rd, er);
    check("msip_read", rd, 32'h0000_0001);
    bus(1'b1, 32'h0000, 32'd0, 4'hF, rd, er);
    check("msip_clr", software_int_out, 1'b0);

    // mtime load and carry into the high word.
    bus(1'b1, 32'hBFFC, 32'd0, 4'hF, rd, er);
    bus(1'b1, 32'hBFF8, 32'hFFFF_FFFF, 4'hF, rd, er);
    bus(1'b0, 32'hBFFC, 32'd0, 4'h0, rd, er);
`ifndef CLINT_PRESCALER_EN
    check("mtime_carry_hi", rd, 32'd1);
`else
    check("mtime_presc_hi", rd, 32'd0);
`endif
    bus(1'b0, 32'hBFF8, 32'd0, 4'h0, rd, er);
`ifndef CLINT_PRESCALER_EN
    check("mtime_carry_lo", rd, 32'd2);
`else
    check("mtime_presc_lo", rd, 32'hFFFF_FFFF);
`endif

    // Reset while a response is pending.
    bus(1'b1, 32'h0000, 32'd1, 4'h1, rd, er);
    req_valid_in = 1'b1; req_we_in = 1'b0; req_addr_in = BASE + 32'hBFF8;
    @(posedge clk); #1;
    req_valid_in = 1'b0;
    check("pre_reset_valid", resp_valid_out, 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("reset_drop_valid", resp_valid_out, 1'b0);
    check("reset_ready", req_ready_out, 1'b1);
    check("reset_sw", software_int_out, 1'b0);
    reset = 1'b1;
    bus(1'b0, 32'h4000, 32'd0, 4'h0, rd, er);
    check("reset_cmp_lo", rd, 32'hFFFF_FFFF);
    bus(1'b0, 32'h0000, 32'd0, 4'h0, rd, er);
    check("reset_msip", rd, 32'd0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
